// File: rtl/window_line_buffer.sv
// Streaming KxK sliding-window generator: one tap chain split into per-row
// segments, raster position counters, and registered window flags/coordinates.
// Optional build macro WINBUF_STRIDE_EN flags only windows on a STRIDE grid.

module window_line_buffer_seg #(
  parameter int DW   = 16,
  parameter int LEN  = 28,
  parameter int NWIN = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift,
  input  logic [DW-1:0]            din,
  output logic [NWIN-1:0][DW-1:0]  win,
  output logic [DW-1:0]            tail
);

  logic [LEN-1:0][DW-1:0] taps;

  always_ff @(posedge clk) begin
    if (!reset)     taps <= '0;
    else if (shift) taps <= {taps[LEN-2:0], din};
  end

  assign win  = taps[NWIN-1:0];
  assign tail = taps[LEN-1];

endmodule

module window_line_buffer #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int STRIDE       = 1,
  localparam int CW = $clog2(IMAGE_WIDTH),
  localparam int RW = $clog2(IMAGE_HEIGHT)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      pixel_valid,
  input  logic [DATA_WIDTH-1:0]                     pixel_in,
  output logic                                      window_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
  output logic [RW-1:0]                             win_row,
  output logic [CW-1:0]                             win_col,
  output logic                                      frame_done
);

  localparam int DW = DATA_WIDTH;
  localparam int K  = KERNEL_SIZE;
  localparam int W  = IMAGE_WIDTH;
  localparam int H  = IMAGE_HEIGHT;

  if (K < 2 || W <= K || H < K || STRIDE < 1) begin : g_param_err
    $error("window_line_buffer: illegal geometry parameters");
  end

  logic [K-1:0][DW-1:0]   tail;
  logic [K*K-1:0][DW-1:0] win;

  // Rows 0..K-2 are full line segments; the last row only needs K taps.
  // The last segment's tail is its oldest tap, i.e. window element (K-1,K-1),
  // so that segment exports only its first K-1 taps as window taps.
  for (genvar r = 0; r < K; r++) begin : g_row
    localparam bit LAST = (r == K-1);
    localparam int LEN  = LAST ? K : W;
    localparam int NW   = LAST ? K-1 : K;

    logic [DW-1:0]         din;
    logic [NW-1:0][DW-1:0] rw;

    if (r == 0) begin : g_head
      assign din = pixel_in;
    end else begin : g_link
      assign din = tail[r-1];
    end

    window_line_buffer_seg #(.DW(DW), .LEN(LEN), .NWIN(NW)) u_seg (
      .clk   (clk),
      .reset (reset),
      .shift (pixel_valid),
      .din   (din),
      .win   (rw),
      .tail  (tail[r])
    );

    for (genvar c = 0; c < NW; c++) begin : g_col
      assign win[r*K+c] = rw[c];
    end
    if (LAST) begin : g_corner
      assign win[K*K-1] = tail[r];
    end
  end

  // Chain taps are registers updated with each accepted pixel, so the window
  // already refers to the pixel accepted last cycle and holds through stalls.
  assign window_out = win;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end, row_end, in_win;

  assign col_end = (col == CW'(W-1));
  assign row_end = (row == RW'(H-1));

`ifdef WINBUF_STRIDE_EN
  localparam int SPW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  // Phase of (col-(K-1)) and (row-(K-1)) modulo STRIDE; 0 outside the valid band.
  logic [SPW-1:0] cph, rph;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cph <= '0;
      rph <= '0;
    end else if (pixel_valid) begin
      if (col_end) begin
        cph <= '0;
        if (row_end || row < RW'(K-1))  rph <= '0;
        else if (rph == SPW'(STRIDE-1)) rph <= '0;
        else                            rph <= rph + SPW'(1);
      end else if (col < CW'(K-1) || cph == SPW'(STRIDE-1)) begin
        cph <= '0;
      end else begin
        cph <= cph + SPW'(1);
      end
    end
  end

  assign in_win = (row >= RW'(K-1)) && (col >= CW'(K-1)) &&
                  (cph == '0) && (rph == '0);
`else
  assign in_win = (row >= RW'(K-1)) && (col >= CW'(K-1));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (pixel_valid) begin
        window_valid <= in_win;
        frame_done   <= col_end && row_end;
        if (in_win) begin
          win_row <= row - RW'(K-1);
          win_col <= col - CW'(K-1);
        end
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer with K=3, W=5, H=4; pixel value = base + raster index.
module tb_window_line_buffer;

  localparam int DW  = 16;
  localparam int K   = 3;
  localparam int W   = 5;
  localparam int H   = 4;
  localparam int NPX = W*H;
  localparam int WOW = K*K*DW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           pixel_valid = 1'b0;
  logic [DW-1:0]  pixel_in = '0;
  logic           window_valid;
  logic [WOW-1:0] window_out;
  logic [1:0]     win_row;
  logic [2:0]     win_col;
  logic           frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic           rec_wv [0:NPX-1];
  logic           rec_fd [0:NPX-1];
  logic [1:0]     rec_wr [0:NPX-1];
  logic [2:0]     rec_wc [0:NPX-1];
  logic [WOW-1:0] rec_wo [0:NPX-1];
  int gap_pulses;
  int gap_changes;

  logic [NPX-1:0] wv_mask;
  int             n_windows;

  window_line_buffer #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .STRIDE(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .window_valid (window_valid),
    .window_out   (window_out),
    .win_row      (win_row),
    .win_col      (win_col),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Element (r,c) of the window after pixel p is the pixel r rows and c columns older.
  function automatic logic [WOW-1:0] exp_window(input int p, input int base);
    logic [WOW-1:0] v;
    v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*DW +: DW] = DW'(base + p - r*W - c);
    return v;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    pixel_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int first, input int last, input int base, input bit gaps);
    logic [WOW-1:0] hold;
    for (int p = first; p <= last; p++) begin
      if (gaps && ($urandom_range(0, 2) == 0 || p == 13)) begin
        hold = window_out;
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          pixel_valid = 1'b0;
          @(posedge clk);
          #1;
          if (window_valid || frame_done) gap_pulses++;
          if (window_out !== hold) gap_changes++;
        end
      end
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_in = DW'(base + p);
      @(posedge clk);
      #1;
      rec_wv[p] = window_valid;
      rec_fd[p] = frame_done;
      rec_wr[p] = win_row;
      rec_wc[p] = win_col;
      rec_wo[p] = window_out;
    end
  endtask

  task automatic test_reset;
    do_reset(3);
    @(posedge clk);
    #1;
    n_cmp += 5;
    if (window_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wv got=%b want=0", window_valid); end
    if (frame_done !== 1'b0)   begin n_bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
    if (win_row !== 2'd0)      begin n_bad++; $display("FAIL reset_row got=%0d want=0", win_row); end
    if (win_col !== 3'd0)      begin n_bad++; $display("FAIL reset_col got=%0d want=0", win_col); end
    if (window_out !== '0)     begin n_bad++; $display("FAIL reset_wo got=%h want=0", window_out); end
  endtask

  task automatic test_first_window;
    logic [WOW-1:0] e;
    do_reset(1);
    run(0, 12, 0, 1'b0);
    for (int p = 0; p < 12; p++) begin
      n_cmp++;
      if (rec_wv[p] !== 1'b0) begin n_bad++; $display("FAIL first_early_wv p=%0d got=%b want=0", p, rec_wv[p]); end
    end
    // rows {12,11,10}, {7,6,5}, {2,1,0}
    e = {16'd0, 16'd1, 16'd2, 16'd5, 16'd6, 16'd7, 16'd10, 16'd11, 16'd12};
    n_cmp += 4;
    if (rec_wv[12] !== 1'b1) begin n_bad++; $display("FAIL first_wv got=%b want=1", rec_wv[12]); end
    if (rec_wr[12] !== 2'd0) begin n_bad++; $display("FAIL first_row got=%0d want=0", rec_wr[12]); end
    if (rec_wc[12] !== 3'd0) begin n_bad++; $display("FAIL first_col got=%0d want=0", rec_wc[12]); end
    if (rec_wo[12] !== e)    begin n_bad++; $display("FAIL first_wo got=%h want=%h", rec_wo[12], e); end
  endtask

  task automatic test_full_frame;
    int nwv, nfd;
    do_reset(1);
    run(0, NPX-1, 0, 1'b0);
    nwv = 0; nfd = 0;
    for (int p = 0; p < NPX; p++) begin
      nwv += int'(rec_wv[p]);
      nfd += int'(rec_fd[p]);
      n_cmp += 2;
      if (rec_wv[p] !== wv_mask[p]) begin n_bad++; $display("FAIL frame_wv p=%0d got=%b want=%b", p, rec_wv[p], wv_mask[p]); end
      if (rec_fd[p] !== (p == NPX-1)) begin n_bad++; $display("FAIL frame_fd p=%0d got=%b want=%b", p, rec_fd[p], p == NPX-1); end
      if (wv_mask[p]) begin
        n_cmp += 3;
        if (rec_wr[p] !== 2'(p/W - (K-1))) begin n_bad++; $display("FAIL frame_row p=%0d got=%0d want=%0d", p, rec_wr[p], p/W-(K-1)); end
        if (rec_wc[p] !== 3'(p%W - (K-1))) begin n_bad++; $display("FAIL frame_col p=%0d got=%0d want=%0d", p, rec_wc[p], p%W-(K-1)); end
        if (rec_wo[p] !== exp_window(p, 0)) begin n_bad++; $display("FAIL frame_wo p=%0d got=%h want=%h", p, rec_wo[p], exp_window(p, 0)); end
      end
    end
    n_cmp += 4;
    if (nwv !== n_windows) begin n_bad++; $display("FAIL frame_nwin got=%0d want=%0d", nwv, n_windows); end
    if (nfd !== 1)         begin n_bad++; $display("FAIL frame_nfd got=%0d want=1", nfd); end
    if (rec_wr[NPX-1] !== 2'd1) begin n_bad++; $display("FAIL frame_last_row got=%0d want=1", rec_wr[NPX-1]); end
    if (rec_wc[NPX-1] !== 3'd2) begin n_bad++; $display("FAIL frame_last_col got=%0d want=2", rec_wc[NPX-1]); end
  endtask

  task automatic test_stall;
    do_reset(1);
    gap_pulses = 0;
    gap_changes = 0;
    run(0, NPX-1, 0, 1'b1);
    for (int p = 0; p < NPX; p++) begin
      n_cmp += 2;
      if (rec_wv[p] !== wv_mask[p]) begin n_bad++; $display("FAIL stall_wv p=%0d got=%b want=%b", p, rec_wv[p], wv_mask[p]); end
      if (rec_fd[p] !== (p == NPX-1)) begin n_bad++; $display("FAIL stall_fd p=%0d got=%b want=%b", p, rec_fd[p], p == NPX-1); end
      if (wv_mask[p]) begin
        n_cmp++;
        if (rec_wo[p] !== exp_window(p, 0)) begin n_bad++; $display("FAIL stall_wo p=%0d got=%h want=%h", p, rec_wo[p], exp_window(p, 0)); end
      end
    end
    n_cmp += 2;
    if (gap_pulses !== 0)  begin n_bad++; $display("FAIL stall_gap_pulse got=%0d want=0", gap_pulses); end
    if (gap_changes !== 0) begin n_bad++; $display("FAIL stall_gap_hold got=%0d want=0", gap_changes); end
  endtask

  task automatic test_back_to_back;
    do_reset(1);
    run(0, NPX-1, 0, 1'b0);
    run(0, NPX-1, 500, 1'b0);
    for (int p = 0; p < NPX; p++) begin
      n_cmp += 2;
      if (rec_wv[p] !== wv_mask[p]) begin n_bad++; $display("FAIL b2b_wv p=%0d got=%b want=%b", p, rec_wv[p], wv_mask[p]); end
      if (rec_fd[p] !== (p == NPX-1)) begin n_bad++; $display("FAIL b2b_fd p=%0d got=%b want=%b", p, rec_fd[p], p == NPX-1); end
      if (wv_mask[p]) begin
        n_cmp += 2;
        if (rec_wc[p] !== 3'(p%W - (K-1))) begin n_bad++; $display("FAIL b2b_col p=%0d got=%0d want=%0d", p, rec_wc[p], p%W-(K-1)); end
        if (rec_wo[p] !== exp_window(p, 500)) begin n_bad++; $display("FAIL b2b_wo p=%0d got=%h want=%h", p, rec_wo[p], exp_window(p, 500)); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    do_reset(1);
    run(0, 8, 1000, 1'b0);
    do_reset(1);
    @(posedge clk);
    #1;
    n_cmp += 2;
    if (window_out !== '0)     begin n_bad++; $display("FAIL mid_wo_clear got=%h want=0", window_out); end
    if (window_valid !== 1'b0) begin n_bad++; $display("FAIL mid_wv_clear got=%b want=0", window_valid); end
    run(0, 12, 0, 1'b0);
    for (int p = 0; p < 12; p++) begin
      n_cmp++;
      if (rec_wv[p] !== 1'b0) begin n_bad++; $display("FAIL mid_early_wv p=%0d got=%b want=0", p, rec_wv[p]); end
    end
    n_cmp += 4;
    if (rec_wv[12] !== 1'b1) begin n_bad++; $display("FAIL mid_wv got=%b want=1", rec_wv[12]); end
    if (rec_wr[12] !== 2'd0) begin n_bad++; $display("FAIL mid_row got=%0d want=0", rec_wr[12]); end
    if (rec_wc[12] !== 3'd0) begin n_bad++; $display("FAIL mid_col got=%0d want=0", rec_wc[12]); end
    if (rec_wo[12] !== exp_window(12, 0)) begin n_bad++; $display("FAIL mid_wo got=%h want=%h", rec_wo[12], exp_window(12, 0)); end
  endtask

`ifdef WINBUF_STRIDE_EN
  task automatic test_stride;
    do_reset(1);
    run(0, NPX-1, 0, 1'b0);
    n_cmp += 7;
    if (rec_wv[12] !== 1'b1) begin n_bad++; $display("FAIL stride_wv12 got=%b want=1", rec_wv[12]); end
    if (rec_wc[12] !== 3'd0) begin n_bad++; $display("FAIL stride_col12 got=%0d want=0", rec_wc[12]); end
    if (rec_wv[13] !== 1'b0) begin n_bad++; $display("FAIL stride_wv13 got=%b want=0", rec_wv[13]); end
    if (rec_wv[14] !== 1'b1) begin n_bad++; $display("FAIL stride_wv14 got=%b want=1", rec_wv[14]); end
    if (rec_wc[14] !== 3'd2) begin n_bad++; $display("FAIL stride_col14 got=%0d want=2", rec_wc[14]); end
    if (rec_wv[19] !== 1'b0) begin n_bad++; $display("FAIL stride_wv19 got=%b want=0", rec_wv[19]); end
    if (rec_fd[19] !== 1'b1) begin n_bad++; $display("FAIL stride_fd19 got=%b want=1", rec_fd[19]); end
  endtask
`endif

  initial begin
`ifdef WINBUF_STRIDE_EN
    wv_mask   = 20'b00000101000000000000;  // p = 12, 14
    n_windows = 2;
`else
    wv_mask   = 20'b11100111000000000000;  // p = 12,13,14,17,18,19
    n_windows = 6;
`endif
    test_reset();
    test_first_window();
    test_full_frame();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef WINBUF_STRIDE_EN
    test_stride();
`endif
    @(negedge clk);
    pixel_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
